// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC and the single-outstanding imem
// req/ack handshake, and feeds ID through an output slot backed by a one-entry skid buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_instr_q;
    logic        kill_q;

    logic        free;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_inc;

    // The slot can take new data if it is empty or ID is consuming it this cycle.
    assign free   = !if_valid_q || (!id_stall && cpu_en);
    assign redir  = redirect_valid && cpu_en;
    assign target = {redirect_target[31:2], 2'b00};
    assign pc_inc = fetch_pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 32'd0;
            if_instr_q  <= 32'd0;
            buf_valid_q <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            if (free) begin
                if_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (redir) begin
                        if_valid_q  <= 1'b0;
                        buf_valid_q <= 1'b0;
                        fetch_pc_q  <= target;
                        req_q       <= 1'b1;
                        addr_q      <= target;
                        state_q     <= WAIT;
                    end else if (cpu_en) begin
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (kill_q || redir) begin
                            // Returned word belongs to a squashed path: drop it and refetch.
                            kill_q <= 1'b0;
                            if (redir) begin
                                if_valid_q  <= 1'b0;
                                buf_valid_q <= 1'b0;
                                fetch_pc_q  <= target;
                                req_q       <= 1'b1;
                                addr_q      <= target;
                            end else if (cpu_en) begin
                                req_q  <= 1'b1;
                                addr_q <= fetch_pc_q;
                            end else begin
                                req_q   <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else if (free) begin
                            if_valid_q <= 1'b1;
                            if_pc_q    <= fetch_pc_q;
                            if_instr_q <= imem_rdata;
                            fetch_pc_q <= pc_inc;
                            if (cpu_en) begin
                                req_q  <= 1'b1;
                                addr_q <= pc_inc;
                            end else begin
                                req_q   <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            buf_valid_q <= 1'b1;
                            buf_pc_q    <= fetch_pc_q;
                            buf_instr_q <= imem_rdata;
                            fetch_pc_q  <= pc_inc;
                            req_q       <= 1'b0;
                            state_q     <= HOLD;
                        end
                    end else if (redir) begin
                        // Request must stay stable at the old address until its ack arrives.
                        kill_q      <= 1'b1;
                        fetch_pc_q  <= target;
                        if_valid_q  <= 1'b0;
                        buf_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        if_valid_q  <= 1'b0;
                        buf_valid_q <= 1'b0;
                        fetch_pc_q  <= target;
                        req_q       <= 1'b1;
                        addr_q      <= target;
                        state_q     <= WAIT;
                    end else if (free) begin
                        if_valid_q  <= buf_valid_q;
                        if_pc_q     <= buf_pc_q;
                        if_instr_q  <= buf_instr_q;
                        buf_valid_q <= 1'b0;
                        req_q       <= 1'b1;
                        addr_q      <= fetch_pc_q;
                        state_q     <= WAIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign fetch_pc  = fetch_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: randomized instruction memory and ID behaviour, with an
// in-order program-stream scoreboard plus handshake/redirect rule checks.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_en = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_en         (cpu_en),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fetch_pc       (fetch_pc)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_consumed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tail_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected program stream: ID must see consecutive words from the last redirect/reset point.
    task automatic sb_fill();
        exp_t e;
        while (sb_q.size() < 8) begin
            e.pc    = tail_pc;
            e.instr = mem_word(tail_pc);
            sb_q.push_back(e);
            tail_pc = tail_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        sb_q.delete();
        tail_pc = pc;
        sb_fill();
    endtask

    // Instruction memory: one request at a time, ack after a random number of cycles.
    int          mem_dmin = 1;
    int          mem_dmax = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) begin
                imem_ack = 1'b0;
                mem_busy = 1'b0;
            end
            if (!mem_busy && imem_req === 1'b1) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = int'($urandom_range(mem_dmax, mem_dmin));
            end
            if (mem_busy && !imem_ack) begin
                if (mem_cnt == 0) begin
                    if (imem_req === 1'b1) check32("addr_at_ack", imem_addr, mem_addr);
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                end else begin
                    mem_cnt--;
                end
            end
        end
    end

    // Monitor: checks edge-to-edge rules and pops the scoreboard on every ID consumption.
    logic        have_prev = 1'b0;
    logic        p_rst, p_redir, p_req, p_ack, p_en;
    logic [31:0] p_tgt, p_addr;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                if (p_rst) begin
                    check32("rst_req", 32'(imem_req), 32'd0);
                    check32("rst_if_valid", 32'(if_valid), 32'd0);
                    check32("rst_if_pc", if_pc, 32'd0);
                    check32("rst_if_instr", if_instr, 32'd0);
                    check32("rst_fetch_pc", fetch_pc, RESET_PC);
                    check32("rst_addr", imem_addr, RESET_PC);
                end else if (p_redir) begin
                    check32("redir_fetch_pc", fetch_pc, p_tgt);
                    check32("redir_flush", 32'(if_valid), 32'd0);
                    check32("redir_req", 32'(imem_req), 32'd1);
                    check32("redir_addr", imem_addr, (p_ack || !p_req) ? p_tgt : p_addr);
                end else if (p_req && !p_ack) begin
                    check32("req_held", 32'(imem_req), 32'd1);
                    check32("addr_held", imem_addr, p_addr);
                end else if (!p_req && !p_en) begin
                    check32("no_req_disabled", 32'(imem_req), 32'd0);
                end
            end
            if (!rst && if_valid === 1'b1 && cpu_en && !id_stall && !redirect_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: consumed pc %h with no expectation", if_pc);
                end else begin
                    e = sb_q.pop_front();
                    check32("if_pc", if_pc, e.pc);
                    check32("if_instr", if_instr, e.instr);
                end
                n_consumed++;
            end
            have_prev = 1'b1;
            p_rst     = rst;
            p_redir   = redirect_valid && cpu_en;
            p_tgt     = redirect_target & 32'hFFFF_FFFC;
            p_req     = (imem_req === 1'b1);
            p_ack     = imem_ack;
            p_en      = cpu_en;
            p_addr    = imem_addr;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            sb_fill();
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        if (cpu_en && !rst) sb_restart(t & 32'hFFFF_FFFC);
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_req(input logic want_ack, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1 && imem_ack == want_ack) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check32(name, 32'(found), 32'd1);
    endtask

    initial begin
        int n0;
        sb_restart(RESET_PC);
        cpu_en = 1'b1;
        step(3);
        rst = 1'b0;

        // Steady streaming from reset: ack two cycles after each request.
        mem_dmin = 2;
        mem_dmax = 2;
        step(10);
        n0 = n_consumed;
        step(30);
        check32("throughput", 32'(n_consumed - n0), 32'd10);

        // Long stall: slot and skid buffer fill, request drops; then release.
        mem_dmin = 1;
        mem_dmax = 1;
        id_stall = 1'b1;
        step(12);
        check32("hold_req_low", 32'(imem_req), 32'd0);
        check32("hold_slot_valid", 32'(if_valid), 32'd1);
        id_stall = 1'b0;
        step(10);

        // Redirect while a fetch is still outstanding.
        mem_dmin = 3;
        mem_dmax = 3;
        wait_req(1'b0, "wait_inflight");
        do_redirect(32'h0000_0100);
        step(12);

        // Redirect landing on the ack edge.
        wait_req(1'b1, "wait_ack");
        do_redirect(32'h0000_0200);
        step(12);

        // Redirect while parked in HOLD with ID stalled.
        mem_dmin = 1;
        mem_dmax = 1;
        id_stall = 1'b1;
        step(12);
        check32("hold2_req_low", 32'(imem_req), 32'd0);
        do_redirect(32'h0000_0042);
        id_stall = 1'b0;
        step(12);

        // Fetch PC wraps past the top of the address space.
        do_redirect(32'hFFFF_FFFB);
        step(20);

        // Disable mid-fetch: the outstanding ack is kept, nothing new is issued.
        mem_dmin = 2;
        mem_dmax = 2;
        wait_req(1'b0, "wait_dis");
        cpu_en = 1'b0;
        step(10);
        check32("dis_req_low", 32'(imem_req), 32'd0);
        check32("dis_slot_valid", 32'(if_valid), 32'd1);
        cpu_en = 1'b1;
        step(10);

        // Reset mid-fetch: the late ack must be ignored.
        mem_dmin = 4;
        mem_dmax = 4;
        wait_req(1'b0, "wait_rst");
        rst    = 1'b1;
        cpu_en = 1'b0;
        sb_restart(RESET_PC);
        step(1);
        rst = 1'b0;
        step(10);
        check32("late_ack_valid", 32'(if_valid), 32'd0);
        check32("late_ack_req", 32'(imem_req), 32'd0);
        check32("late_ack_pc", fetch_pc, RESET_PC);
        cpu_en = 1'b1;

        // Randomized traffic.
        mem_dmin = 0;
        mem_dmax = 3;
        for (int i = 0; i < 3000; i++) begin
            cpu_en   = ($urandom_range(9, 0) != 0);
            id_stall = ($urandom_range(2, 0) == 0);
            if ($urandom_range(19, 0) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                              : $urandom;
                if (cpu_en) sb_restart(redirect_target & 32'hFFFF_FFFC);
            end else begin
                redirect_valid = 1'b0;
            end
            step(1);
        end
        redirect_valid = 1'b0;
        step(5);
        check32("progress", 32'(n_consumed >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
